seq_add_sub: RTL and testbench
==============================

# seq_add_sub

Parametrised, slice-serial adder/subtractor for the calculator datapath. It generalises the 4-bit ripple-carry adder: operand width `WIDTH`, with the add carried out `SLICE` bits per clock. It adds a subtract mode and signed-overflow detection, and uses a start/busy/done handshake. It sits between the operand registers and the result/display path and produces one registered result per operation.

## Interface
- `WIDTH`, default 16: operand and result width in bits. Must be a multiple of `SLICE`.
- `SLICE`, default 4: bits processed per clock. N = WIDTH/SLICE cycles per operation. `SLICE = WIDTH` is legal (N = 1).
- `i_clk` input, 1: clock, rising-edge.
- `i_reset` input, 1: synchronous, active-high reset.
- `i_start` input, 1: request. Sampled only while `o_busy` = 0.
- `i_mode` input, 1: 0 = add (a + b + i_c), 1 = subtract (a − b). Sampled with `i_start`.
- `i_c` input, 1: carry-in, add mode only. Ignored in subtract mode.
- `i_a`, `i_b` input, WIDTH: operands. Sampled with `i_start`.
- `o_sum` output, WIDTH: result, held until the next completion.
- `o_c` output, 1: carry out of the MSB. In subtract mode, 1 = no borrow.
- `o_ovf` output, 1: two's-complement signed overflow.
- `o_busy` output, 1: operation in progress.
- `o_done` output, 1: one-cycle pulse; result outputs valid and newly updated.

## Operation
- FSM states: IDLE and RUN.
- IDLE → RUN when `i_start` = 1 at a rising edge. At that edge:
  - latch `i_a` into A;
  - latch B = `i_b` (add) or ~`i_b` (subtract);
  - set the carry register to `i_c` (add) or 1 (subtract);
  - set slice index k = 0 and `o_busy` = 1.
- RUN: each edge computes slice k, i.e. bits [k·SLICE +: SLICE] of A + B + carry.
  - The slice sum is written into an internal accumulator, not into `o_sum`.
  - The carry register takes the slice carry-out, and k increments.
- On the edge that computes slice N−1:
  - `o_sum` ← accumulator with the final slice;
  - `o_c` ← final carry;
  - `o_ovf` ← (A[W−1] == B[W−1]) && (sum[W−1] != A[W−1]), where B is the effective (possibly inverted) operand;
  - `o_done` ← 1, `o_busy` ← 0, state → IDLE.
- `o_sum`, `o_c` and `o_ovf` never show partial results. They change only on the completion edge and on reset.
- `i_start` while `o_busy` = 1 is ignored. Operand or mode changes during RUN have no effect.
- Slice counter width is clog2(N), minimum 1 bit. No wrap beyond N−1.

## Timing
- Reset (`i_reset` = 1 at an edge) sets: state IDLE, `o_sum` = 0, `o_c` = 0, `o_ovf` = 0, `o_busy` = 0, `o_done` = 0, accumulator, carry and k = 0. Reset has priority over `i_start`.
- Reset mid-RUN aborts the operation. No `o_done` pulse is generated for it, and the result outputs are cleared to 0.
- Start accepted at edge E0: `o_busy` is high from E0 through edge E0+N−1.
  - `o_done` = 1 and the new result are visible in the cycle after edge E0+N.
  - Latency is N cycles.
- `o_busy` falls on the same edge on which `o_done` rises.
- `o_done` stays high for exactly one cycle. A start sampled during the `o_done` cycle is accepted, because `o_busy` = 0.
- Maximum throughput is one operation per N+1 cycles: the start edge plus N compute edges.
- The combinational path per cycle is a SLICE-bit ripple only.

## Test plan
All scenarios use WIDTH = 16, SLICE = 4 (N = 4) unless stated.
1. Add 0x1234 + 0x4321, `i_c` = 0 → after exactly 4 edges, `o_done` pulses for 1 cycle; `o_sum` = 0x5555, `o_c` = 0, `o_ovf` = 0. `o_busy` is high for 4 cycles.
2. Add 0xFFFF + 0x0000, `i_c` = 1 → `o_sum` = 0x0000, `o_c` = 1, `o_ovf` = 0. Add 0x7FFF + 0x0001 → `o_sum` = 0x8000, `o_c` = 0, `o_ovf` = 1.
3. Subtract 0x0005 − 0x0007 with `i_c` = 1 (must be ignored) → `o_sum` = 0xFFFE, `o_c` = 0, `o_ovf` = 0. Subtract 0x8000 − 0x0001 → `o_sum` = 0x7FFF, `o_c` = 1, `o_ovf` = 1.
4. Handshake:
   - Pulse `i_start` with new operands at cycles 1–3 of a running add → ignored, and the first result is unchanged.
   - Assert `i_start` in the `o_done` cycle with 0x0001 + 0x0001 → accepted; second `o_done` 5 cycles after the first, with `o_sum` = 0x0002.
   - Between completions, `o_sum` holds its previous value with no partial updates.
5. Start 0x1111 + 0x2222, then assert `i_reset` at the 2nd RUN edge → all outputs are 0 on the next cycle and no `o_done` pulse occurs. A subsequent 0x0003 + 0x0004 gives 0x0007 with correct latency.
6. Parameter sweep:
   - WIDTH = 8, SLICE = 1: 0x80 − 0x01 → 0x7F, `o_ovf` = 1, `o_done` 8 cycles after start.
   - WIDTH = 8, SLICE = 8: 0xFF + 0x01 → 0x00, `o_c` = 1, `o_done` 1 cycle after start.

Source files
------------

// File: rtl/seq_add_sub.sv
// Slice-serial adder/subtractor: WIDTH-bit add or subtract carried out SLICE bits
// per clock, with start/busy/done handshake and signed-overflow detection.
module seq_add_sub #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_c,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_c,
    output logic             o_ovf,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_state
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic             c_q, c_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic [SLICE:0]   slice_res;
    int               base;

    assign base = int'(k_q) * SLICE;

    // Handshake: a request is taken when i_start is high at an edge while o_busy
    // is low; o_done pulses for one cycle on the edge o_busy falls, and the result
    // outputs are only ever written on that same edge (or cleared by reset).
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        k_d       = k_q;
        c_d       = c_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        slice_res = {1'b0, a_q[base +: SLICE]} + {1'b0, b_q[base +: SLICE]}
                  + {{SLICE{1'b0}}, carry_q};

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    a_d     = i_a;
                    // Subtract is a + ~b + 1, so the carry-in supplies the +1.
                    b_d     = i_mode ? ~i_b : i_b;
                    carry_d = i_mode ? 1'b1 : i_c;
                    k_d     = '0;
                    acc_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d[base +: SLICE] = slice_res[SLICE-1:0];
                carry_d              = slice_res[SLICE];
                if (k_q == K_LAST) begin
                    sum_d   = acc_d;
                    c_d     = slice_res[SLICE];
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    k_d     = '0;
                    state_d = ST_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign o_sum   = sum_q;
    assign o_c     = c_q;
    assign o_ovf   = ovf_q;
    assign o_busy  = (state_q == ST_RUN);
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Directed bench for seq_add_sub: vector table on the 16/4 build, handshake and
// reset corner sequences, plus 8/1 and 8/8 parameter builds.
module tb_seq_add_sub;

    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] exp_sum;
        logic        exp_c;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, mode, cin;
    logic [15:0] a, b;
    logic [15:0] sum;
    logic        cout, ovf, busy, done, st;

    logic       s1_start, s1_mode, s1_c, s1_cout, s1_ovf, s1_busy, s1_done, s1_st;
    logic [7:0] s1_a, s1_b, s1_sum;
    logic       s8_start, s8_mode, s8_c, s8_cout, s8_ovf, s8_busy, s8_done, s8_st;
    logic [7:0] s8_a, s8_b, s8_sum;

    int n_total = 0;
    int n_pass  = 0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    seq_add_sub #(.WIDTH(16), .SLICE(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_mode(mode), .i_c(cin),
        .i_a(a), .i_b(b), .o_sum(sum), .o_c(cout), .o_ovf(ovf), .o_busy(busy),
        .o_done(done), .o_state(st)
    );

    seq_add_sub #(.WIDTH(8), .SLICE(1)) dut_s1 (
        .i_clk(clk), .i_reset(reset), .i_start(s1_start), .i_mode(s1_mode), .i_c(s1_c),
        .i_a(s1_a), .i_b(s1_b), .o_sum(s1_sum), .o_c(s1_cout), .o_ovf(s1_ovf),
        .o_busy(s1_busy), .o_done(s1_done), .o_state(s1_st)
    );

    seq_add_sub #(.WIDTH(8), .SLICE(8)) dut_s8 (
        .i_clk(clk), .i_reset(reset), .i_start(s8_start), .i_mode(s8_mode), .i_c(s8_c),
        .i_a(s8_a), .i_b(s8_b), .o_sum(s8_sum), .o_c(s8_cout), .o_ovf(s8_ovf),
        .o_busy(s8_busy), .o_done(s8_done), .o_state(s8_st)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Start one op on the 16-bit build, wait for o_done, return result and latency.
    task automatic run_op(input logic m, input logic [15:0] ia, input logic [15:0] ib,
                          input logic ic, output logic [15:0] r_sum, output logic r_c,
                          output logic r_ovf, output int lat, output logic busy_ok);
        @(negedge clk);
        mode = m; a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_ok = busy;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        r_sum = sum; r_c = cout; r_ovf = ovf;
        @(posedge clk);
        #1 check("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    // Start one op on an 8-bit build (sel 0: SLICE=1, sel 1: SLICE=8).
    task automatic run8(input bit sel, input logic m, input logic [7:0] ia, input logic [7:0] ib,
                        output logic [7:0] r_sum, output logic r_c, output logic r_ovf,
                        output int lat);
        @(negedge clk);
        if (sel) begin s8_mode = m; s8_a = ia; s8_b = ib; s8_c = 1'b0; s8_start = 1'b1; end
        else     begin s1_mode = m; s1_a = ia; s1_b = ib; s1_c = 1'b0; s1_start = 1'b1; end
        @(posedge clk);
        #1 s1_start = 1'b0; s8_start = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (sel ? s8_done : s1_done) break;
        end
        r_sum = sel ? s8_sum  : s1_sum;
        r_c   = sel ? s8_cout : s1_cout;
        r_ovf = sel ? s8_ovf  : s1_ovf;
    endtask

    initial begin
        logic [15:0] r_sum;
        logic [7:0]  r8;
        logic        r_c, r_ovf, busy_ok, saw_done;
        int          lat;

        vecs[0] = '{1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 16'h0003, 16'h0003, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b1};

        reset = 1'b1; start = 1'b0; mode = 1'b0; cin = 1'b0; a = '0; b = '0;
        s1_start = 1'b0; s1_mode = 1'b0; s1_c = 1'b0; s1_a = '0; s1_b = '0;
        s8_start = 1'b0; s8_mode = 1'b0; s8_c = 1'b0; s8_a = '0; s8_b = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_sum",  {16'd0, sum}, 32'd0);
        check("reset_c",    {31'd0, cout}, 32'd0);
        check("reset_ovf",  {31'd0, ovf}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].c, r_sum, r_c, r_ovf, lat, busy_ok);
            check($sformatf("vec%0d_sum", i), {16'd0, r_sum}, {16'd0, vecs[i].exp_sum});
            check($sformatf("vec%0d_c", i), {31'd0, r_c}, {31'd0, vecs[i].exp_c});
            check($sformatf("vec%0d_ovf", i), {31'd0, r_ovf}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("vec%0d_latency", i), lat, 4);
            check($sformatf("vec%0d_busy", i), {31'd0, busy_ok}, 32'd1);
        end

        // Handshake: restarts during RUN are ignored, start in the done cycle is taken.
        @(negedge clk);
        mode = 1'b0; a = 16'h1000; b = 16'h0200; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            mode = 1'b1; a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
            check($sformatf("hold_prev_sum_%0d", i), {16'd0, sum}, 32'h8000);
            check($sformatf("busy_run_%0d", i), {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1 start = 1'b0;
        end
        @(posedge clk);
        #1;
        check("hs_first_done", {31'd0, done}, 32'd1);
        check("hs_first_sum", {16'd0, sum}, 32'h1200);
        mode = 1'b0; a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
            check($sformatf("hs_hold_%0d", lat), {16'd0, sum}, 32'h1200);
        end
        check("hs_second_gap", lat, 5);
        check("hs_second_sum", {16'd0, sum}, 32'h0002);

        // Reset on the 2nd RUN edge aborts and clears the result.
        @(negedge clk);
        mode = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("abort_sum",  {16'd0, sum}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (done) saw_done = 1'b1;
        end
        check("abort_no_done", {31'd0, saw_done}, 32'd0);
        run_op(1'b0, 16'h0003, 16'h0004, 1'b0, r_sum, r_c, r_ovf, lat, busy_ok);
        check("post_abort_sum", {16'd0, r_sum}, 32'h0007);
        check("post_abort_latency", lat, 4);

        // Parameter builds.
        run8(1'b0, 1'b1, 8'h80, 8'h01, r8, r_c, r_ovf, lat);
        check("s1_sum", {24'd0, r8}, 32'h7F);
        check("s1_ovf", {31'd0, r_ovf}, 32'd1);
        check("s1_c", {31'd0, r_c}, 32'd1);
        check("s1_latency", lat, 8);
        run8(1'b1, 1'b0, 8'hFF, 8'h01, r8, r_c, r_ovf, lat);
        check("s8_sum", {24'd0, r8}, 32'h00);
        check("s8_c", {31'd0, r_c}, 32'd1);
        check("s8_ovf", {31'd0, r_ovf}, 32'd0);
        check("s8_latency", lat, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
